// File: rtl/spr_case_filter_l.sv
// spr_case_filter_l: left-path subpixel filter. It picks one of seven kernels
// from the border/original/edge flags and filters prev/curr/next over 3 stages.
// Ports: clk, rst_n (async, active-low); i_hs/i_vs line/frame qualifiers;
//   is_boarder, is_original, is_edge[3:0] case flags; prev/curr/next 12b samples;
//   o_hs/o_vs (3-cycle delayed), o_pix filtered value, o_case kernel code,
//   o_edge_cnt per-line edge-class count, o_edge_cnt_vld one-cycle update strobe.
module spr_case_filter_l (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic        is_boarder,
    input  logic        is_original,
    input  logic [3:0]  is_edge,
    input  logic [11:0] prev,
    input  logic [11:0] curr,
    input  logic [11:0] next,
    output logic        o_hs,
    output logic        o_vs,
    output logic [11:0] o_pix,
    output logic [2:0]  o_case,
    output logic [11:0] o_edge_cnt,
    output logic        o_edge_cnt_vld
);

    localparam logic [2:0] C_IDLE   = 3'd0;
    localparam logic [2:0] C_BORDER = 3'd1;
    localparam logic [2:0] C_ORIG   = 3'd2;
    localparam logic [2:0] C_EDGE2  = 3'd3;
    localparam logic [2:0] C_EDGE3  = 3'd4;
    localparam logic [2:0] C_EDGE4  = 3'd5;
    localparam logic [2:0] C_EDGE5  = 3'd6;
    localparam logic [2:0] C_DFLT   = 3'd7;

    // Stage 1: samples and encoded kernel
    logic [2:0]  w_case;
    logic        r1_hs, r1_vs;
    logic [2:0]  r1_case;
    logic [11:0] r1_prev, r1_curr, r1_next;

    always_comb begin
        w_case = C_IDLE;
        if (i_hs && i_vs) begin
            if (is_boarder)       w_case = C_BORDER;
            else if (is_original) w_case = C_ORIG;
            else if (is_edge[3])  w_case = C_EDGE2;
            else if (is_edge[2])  w_case = C_EDGE3;
            else if (is_edge[1])  w_case = C_EDGE4;
            else if (is_edge[0])  w_case = C_EDGE5;
            else                  w_case = C_DFLT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_hs   <= 1'b0;
            r1_vs   <= 1'b0;
            r1_case <= C_IDLE;
            r1_prev <= '0;
            r1_curr <= '0;
            r1_next <= '0;
        end else begin
            r1_hs   <= i_hs;
            r1_vs   <= i_vs;
            r1_case <= w_case;
            r1_prev <= prev;
            r1_curr <= curr;
            r1_next <= next;
        end
    end

    // Stage 2: 14-bit sum including rounding constant, plus shift amount
    logic [13:0] w_p, w_c, w_n, w_c3;
    logic [13:0] w_sum;
    logic [1:0]  w_sh;
    logic        r2_hs, r2_vs;
    logic [2:0]  r2_case;
    logic [13:0] r2_sum;
    logic [1:0]  r2_sh;

    assign w_p  = {2'b00, r1_prev};
    assign w_c  = {2'b00, r1_curr};
    assign w_n  = {2'b00, r1_next};
    assign w_c3 = w_c + {w_c[12:0], 1'b0};

    always_comb begin
        w_sum = '0;
        w_sh  = 2'd0;
        case (r1_case)
            C_BORDER, C_ORIG, C_EDGE2: begin
                w_sum = w_c;
            end
            C_EDGE3: begin
                w_sum = w_c3 + w_p + 14'd2;
                w_sh  = 2'd2;
            end
            C_EDGE4: begin
                w_sum = w_c3 + w_n + 14'd2;
                w_sh  = 2'd2;
            end
            C_EDGE5: begin
                w_sum = w_c + w_n + 14'd1;
                w_sh  = 2'd1;
            end
            C_DFLT: begin
                w_sum = w_p + {w_c[12:0], 1'b0} + w_n + 14'd2;
                w_sh  = 2'd2;
            end
            default: begin
                w_sum = '0;
                w_sh  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_hs   <= 1'b0;
            r2_vs   <= 1'b0;
            r2_case <= C_IDLE;
            r2_sum  <= '0;
            r2_sh   <= 2'd0;
        end else begin
            r2_hs   <= r1_hs;
            r2_vs   <= r1_vs;
            r2_case <= r1_case;
            r2_sum  <= w_sum;
            r2_sh   <= w_sh;
        end
    end

    // Stage 3: shift and clamp to 12 bits
    logic [13:0] w_shifted;
    logic [11:0] w_sat;

    assign w_shifted = r2_sum >> r2_sh;
    assign w_sat     = (|w_shifted[13:12]) ? 12'hFFF : w_shifted[11:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_hs   <= 1'b0;
            o_vs   <= 1'b0;
            o_case <= C_IDLE;
            o_pix  <= '0;
        end else begin
            o_hs   <= r2_hs;
            o_vs   <= r2_vs;
            o_case <= r2_case;
            o_pix  <= w_sat;
        end
    end

    // Edge statistics on the output side
    logic        r_hs_d;
    logic [11:0] r_cnt;
    logic        w_fall;
    logic        w_edge_px;
    logic [11:0] w_cnt_inc;

    assign w_fall    = r_hs_d & ~o_hs;
    assign w_edge_px = o_hs && o_vs && (o_case >= C_EDGE2) && (o_case <= C_EDGE5);
    assign w_cnt_inc = (w_edge_px && r_cnt != 12'hFFF) ? r_cnt + 12'd1 : r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs_d         <= 1'b0;
            r_cnt          <= '0;
            o_edge_cnt     <= '0;
            o_edge_cnt_vld <= 1'b0;
        end else begin
            r_hs_d         <= o_hs;
            o_edge_cnt_vld <= w_fall;
            if (w_fall) begin
                o_edge_cnt <= w_cnt_inc;
                r_cnt      <= '0;
            end else if (!o_vs) begin
                r_cnt      <= '0;
            end else begin
                r_cnt      <= w_cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_spr_case_filter_l.sv
// tb_spr_case_filter_l: directed vector table for the kernels plus
// hand-written line-count and mid-line-reset sequences.
module tb_spr_case_filter_l;

    logic        clk;
    logic        rst_n;
    logic        i_hs, i_vs, is_boarder, is_original;
    logic [3:0]  is_edge;
    logic [11:0] prev, curr, next;
    logic        o_hs, o_vs;
    logic [11:0] o_pix;
    logic [2:0]  o_case;
    logic [11:0] o_edge_cnt;
    logic        o_edge_cnt_vld;

    int n_chk = 0;
    int n_err = 0;

    spr_case_filter_l dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_hs           (i_hs),
        .i_vs           (i_vs),
        .is_boarder     (is_boarder),
        .is_original    (is_original),
        .is_edge        (is_edge),
        .prev           (prev),
        .curr           (curr),
        .next           (next),
        .o_hs           (o_hs),
        .o_vs           (o_vs),
        .o_pix          (o_pix),
        .o_case         (o_case),
        .o_edge_cnt     (o_edge_cnt),
        .o_edge_cnt_vld (o_edge_cnt_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hs;
        logic        vs;
        logic        b;
        logic        o;
        logic [3:0]  e;
        logic [11:0] p;
        logic [11:0] c;
        logic [11:0] n;
        logic [11:0] xpix;
        logic [2:0]  xcase;
    } vec_t;

    localparam int NV = 16;
    vec_t vt [NV];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic hs, input logic vs, input logic b,
                         input logic o, input logic [3:0] e,
                         input logic [11:0] p, input logic [11:0] c,
                         input logic [11:0] n);
        i_hs        = hs;
        i_vs        = vs;
        is_boarder  = b;
        is_original = o;
        is_edge     = e;
        prev        = p;
        curr        = c;
        next        = n;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 12'd0, 12'd0, 12'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive n active pixels; emask selects edge pixels, bmask border pixels
    task automatic drive_line(input int n, input logic [15:0] emask,
                              input logic [15:0] bmask);
        logic [3:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = emask[i] ? (4'b1000 >> (i % 4)) : 4'b0000;
            drive(1'b1, 1'b1, bmask[i], 1'b0, e,
                  12'(i * 3), 12'(i * 7 + 1), 12'(i * 5));
        end
    endtask

    // End the line and watch a bounded window for the strobe
    task automatic end_line(input int cycles, output int nstb,
                            output int val);
        nstb = 0;
        val  = -1;
        @(negedge clk);
        idle();
        i_vs = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (o_edge_cnt_vld) begin
                nstb++;
                val = int'(o_edge_cnt);
            end
        end
    endtask

    int nstb, val;

    initial begin
        vt[0]  = '{1, 1, 0, 0, 4'b0000, 12'd100,  12'd200,  12'd300,  12'd200,  3'd7};
        vt[1]  = '{1, 1, 0, 0, 4'b0100, 12'd400,  12'd800,  12'd999,  12'd700,  3'd4};
        vt[2]  = '{1, 1, 0, 0, 4'b0010, 12'd55,   12'd800,  12'd0,    12'd600,  3'd5};
        vt[3]  = '{1, 1, 0, 0, 4'b0001, 12'd9,    12'd801,  12'd0,    12'd401,  3'd6};
        vt[4]  = '{1, 1, 1, 1, 4'b1111, 12'd1,    12'd1234, 12'd2,    12'd1234, 3'd1};
        vt[5]  = '{1, 1, 0, 0, 4'b0111, 12'd100,  12'd200,  12'd300,  12'd175,  3'd4};
        vt[6]  = '{1, 1, 0, 0, 4'b0000, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 3'd7};
        vt[7]  = '{1, 1, 0, 0, 4'b0100, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 3'd4};
        vt[8]  = '{0, 1, 0, 0, 4'b0100, 12'd500,  12'd600,  12'd700,  12'd0,    3'd0};
        vt[9]  = '{1, 1, 0, 1, 4'b1000, 12'd3,    12'd77,   12'd4,    12'd77,   3'd2};
        vt[10] = '{1, 1, 0, 0, 4'b1000, 12'd3,    12'd500,  12'd4,    12'd500,  3'd3};
        vt[11] = '{1, 0, 0, 0, 4'b0000, 12'd10,   12'd20,   12'd30,   12'd0,    3'd0};
        vt[12] = '{1, 1, 0, 0, 4'b0001, 12'd0,    12'd4095, 12'd4095, 12'd4095, 3'd6};
        vt[13] = '{1, 1, 0, 0, 4'b0000, 12'd0,    12'd1,    12'd0,    12'd1,    3'd7};
        vt[14] = '{1, 1, 0, 0, 4'b0010, 12'd7,    12'd1,    12'd1,    12'd1,    3'd5};
        vt[15] = '{1, 1, 0, 0, 4'b0001, 12'd7,    12'd0,    12'd1,    12'd1,    3'd6};

        rst_n = 1'b0;
        idle();
        #3;
        chk("rst_pix", int'(o_pix), 0);
        chk("rst_case", int'(o_case), 0);
        chk("rst_hs", int'(o_hs), 0);
        chk("rst_vs", int'(o_vs), 0);
        chk("rst_cnt", int'(o_edge_cnt), 0);
        chk("rst_vld", int'(o_edge_cnt_vld), 0);
        do_reset();

        // Streamed kernel vectors: output for vector i appears 3 cycles later
        for (int i = 0; i < NV + 3; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                chk($sformatf("v%0d_pix", i - 3), int'(o_pix),
                    int'(vt[i-3].xpix));
                chk($sformatf("v%0d_case", i - 3), int'(o_case),
                    int'(vt[i-3].xcase));
                chk($sformatf("v%0d_hs", i - 3), int'(o_hs),
                    int'(vt[i-3].hs));
                chk($sformatf("v%0d_vs", i - 3), int'(o_vs),
                    int'(vt[i-3].vs));
            end
            if (i < NV)
                drive(vt[i].hs, vt[i].vs, vt[i].b, vt[i].o, vt[i].e,
                      vt[i].p, vt[i].c, vt[i].n);
            else
                idle();
        end

        // Line of 10 with edges on 2,5,7 and a border pixel at 0 that
        // also carries an edge flag (must not count)
        do_reset();
        drive_line(10, 16'b0000_0000_1010_0101, 16'b0000_0000_0000_0001);
        end_line(12, nstb, val);
        chk("line1_strobes", nstb, 1);
        chk("line1_cnt", val, 3);
        chk("line1_hold", int'(o_edge_cnt), 3);

        // Mid-line reset after 5 active pixels
        drive_line(5, 16'b0000_0000_0001_1010, 16'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 12'd9, 12'd9, 12'd9);
        rst_n = 1'b0;
        #1;
        chk("mrst_pix", int'(o_pix), 0);
        chk("mrst_case", int'(o_case), 0);
        chk("mrst_hs", int'(o_hs), 0);
        chk("mrst_cnt", int'(o_edge_cnt), 0);
        chk("mrst_vld", int'(o_edge_cnt_vld), 0);
        @(negedge clk);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        end_line(8, nstb, val);
        chk("mrst_nostrobe", nstb, 0);

        drive_line(6, 16'b0000_0000_0001_0010, 16'b0);
        end_line(12, nstb, val);
        chk("line2_strobes", nstb, 1);
        chk("line2_cnt", val, 2);

        drive_line(7, 16'b0, 16'b0);
        end_line(12, nstb, val);
        chk("line3_strobes", nstb, 1);
        chk("line3_cnt", val, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/spr_case_filter_l.md
# spr_case_filter_l

Left-path subpixel-rendering filter: the consumer of the per-pixel special-case flags (border / original / edge class) produced by the left-path special-case detector. For each active pixel it selects one of seven filter kernels on the aligned prev/curr/next 12-bit samples, computes the filtered subpixel value in a 3-stage pipeline, and keeps hs/vs aligned with the data. It also counts edge-class pixels per line for the SPR statistics path.

## Interface
- Parameters: none. Pixel width fixed at 12 bits, counter width fixed at 12 bits.
- clk  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_hs  in  1  line-active qualifier, aligned with the flags.
- i_vs  in  1  frame-active qualifier, aligned with the flags.
- is_boarder  in  1  first-pixel-of-line flag.
- is_original  in  1  pass-through flag.
- is_edge  in  4  {edge2, edge3, edge4, edge5} class flags.
- prev, curr, next  in  12 each  neighbour samples, already delayed by the caller to match the flag register.
- o_hs, o_vs  out  1 each  i_hs/i_vs delayed 3 cycles.
- o_pix  out  12  filtered subpixel value.
- o_case  out  3  selected kernel code (debug/statistics).
- o_edge_cnt  out  12  edge-class pixel count of the last completed line.
- o_edge_cnt_vld  out  1  one-cycle strobe when o_edge_cnt updates.

## Operation
- Input is active when i_hs && i_vs. Inactive input yields case 0 and pixel 0.
- Case selection priority, highest first:
  - 1 border: curr
  - 2 original: curr
  - 3 edge2 (is_edge[3]): curr
  - 4 edge3 (is_edge[2]): (3*curr + prev + 2) >> 2
  - 5 edge4 (is_edge[1]): (3*curr + next + 2) >> 2
  - 6 edge5 (is_edge[0]): (curr + next + 1) >> 1
  - 7 default: (prev + 2*curr + next + 2) >> 2
- Multiple edge bits set: the highest bit wins. The other flags are ignored when border/original is set.
- Arithmetic: sums are 14-bit unsigned, round-half-up as above, result saturated to 4095. The saturation is defensive; it is unreachable for legal 12-bit inputs.
- Pipeline:
  - S1 registers the samples and encodes the case.
  - S2 forms the 14-bit sum and the shift amount.
  - S3 rounds/saturates into o_pix and registers o_case.
- Edge counter:
  - 12-bit internal counter, incremented on each output cycle with o_hs && o_vs and o_case in 3..6. It saturates at 4095.
  - On o_hs falling (registered 1 -> 0): o_edge_cnt <= counter (including a same-cycle increment, which cannot occur since o_hs is then 0), o_edge_cnt_vld = 1 for one cycle, counter <= 0.
  - o_vs low: the counter is held at 0. No strobe is generated unless an o_hs falling edge occurs.

## Timing
- Latency: input cycle N -> o_pix/o_case/o_hs/o_vs at cycle N+3. Throughput is 1 pixel per clock with no stall or back-pressure.
- o_edge_cnt_vld is asserted in the cycle after the first o_hs == 0 cycle that follows o_hs == 1. o_edge_cnt is held until the next strobe.
- Reset (rst_n low, asynchronous) sets every output, all pipeline stages, the counter and the hs edge register to 0. Mid-line reset drops the line with no strobe. After reset release, the first valid output is 3 cycles after the first active input.
- Blanking mid-pipeline: each stage carries its own qualifier, so active pixels already in flight complete normally.

## Test plan
- Default kernel: prev=100, curr=200, next=300, no flags, hs=vs=1 -> 3 cycles later o_pix=200, o_case=7, o_hs=o_vs=1.
- Edge3/edge4/edge5:
  - prev=400, curr=800, is_edge=4'b0100 -> o_pix=700, o_case=4.
  - next=0, curr=800, is_edge=4'b0010 -> o_pix=600, o_case=5.
  - curr=801, next=0, is_edge=4'b0001 -> o_pix=401, o_case=6.
- Priority: is_boarder=1, is_original=1, is_edge=4'b1111, curr=1234 -> o_pix=1234, o_case=1. Then is_edge=4'b0111 alone -> o_case=4.
- Extremes: prev=curr=next=4095, default and edge3 cases -> o_pix=4095 with no wrap. i_hs=0 with nonzero data -> o_pix=0, o_case=0, o_hs=0 after 3 cycles.
- Line count: 10 active pixels with edge flags on 3 of them, then hs low -> o_edge_cnt=3 with a single 1-cycle o_edge_cnt_vld; the next line with 0 edges reports 0.
- Reset mid-line: rst_n=0 after 5 active pixels -> all outputs 0 immediately, no strobe. After release, a new line with 2 edges reports o_edge_cnt=2.
